// File: rtl/split_pkg.sv
// Shared types and defaults for the sequential shifted-variable split checker.
package split_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int NUM_CH_D  = 4;
    localparam int VAR_W_D   = 60;
    localparam int SHIFT_W_D = 6;

    // A single channel still needs a one-bit index register.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/split_shift_reduce.sv
// One channel of the checker: shifted-variable nonzero test with polarity.
module split_shift_reduce
    import split_pkg::*;
#(
    parameter int VAR_W   = VAR_W_D,
    parameter int SHIFT_W = SHIFT_W_D
) (
    input  logic [VAR_W-1:0]   var_i,
    input  logic [SHIFT_W-1:0] shamt_i,
    input  logic               mode_i,
    output logic               pass_o
);

    logic             in_range;
    logic [VAR_W-1:0] shifted;
    logic             r;

    // Shifts at or past the slot width empty it rather than wrapping.
    assign in_range = 32'(shamt_i) < VAR_W;
    assign shifted  = var_i >> shamt_i;
    assign r        = in_range & (|shifted);
    assign pass_o   = mode_i ? ~r : r;

endmodule

// File: rtl/split_shift_seq.sv
// Sequential split checker: captures a bundle, evaluates one channel per clock.
module split_shift_seq
    import split_pkg::*;
#(
    parameter int NUM_CH     = NUM_CH_D,
    parameter int VAR_W      = VAR_W_D,
    parameter int SHIFT_W    = SHIFT_W_D,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_CH*VAR_W-1:0]   vars,
    input  logic [NUM_CH*SHIFT_W-1:0] shamt,
    input  logic [NUM_CH-1:0]         mode,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      x,
    output logic [NUM_CH-1:0]         ch_result
);

    localparam int IDXW = idx_w(NUM_CH);
    localparam logic [IDXW-1:0] LAST = IDXW'(NUM_CH - 1);

    state_e state_q, state_d;

    logic [NUM_CH*VAR_W-1:0]   vars_q, vars_d;
    logic [NUM_CH*SHIFT_W-1:0] shamt_q, shamt_d;
    logic [NUM_CH-1:0]         mode_q, mode_d;
    logic [IDXW-1:0]           idx_q, idx_d;
    logic [NUM_CH-1:0]         res_q, res_d, res_upd;
    logic                      x_q, x_d;

    logic [VAR_W-1:0]   var_sel;
    logic [SHIFT_W-1:0] shamt_sel;
    logic               mode_sel;
    logic               pass;
    logic               accept;
    logic               finish;

    always_comb begin
        var_sel   = '0;
        shamt_sel = '0;
        mode_sel  = 1'b0;
        res_upd   = res_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (idx_q == IDXW'(i)) begin
                var_sel    = vars_q[i*VAR_W +: VAR_W];
                shamt_sel  = shamt_q[i*SHIFT_W +: SHIFT_W];
                mode_sel   = mode_q[i];
                res_upd[i] = pass;
            end
        end
    end

    split_shift_reduce #(
        .VAR_W   (VAR_W),
        .SHIFT_W (SHIFT_W)
    ) u_reduce (
        .var_i   (var_sel),
        .shamt_i (shamt_sel),
        .mode_i  (mode_sel),
        .pass_o  (pass)
    );

    assign accept = (state_q == IDLE) && in_valid;
    assign finish = (idx_q == LAST) || (EARLY_EXIT && !pass);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid)  state_d = EVAL;
            EVAL:    if (finish)    state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        x         = x_q;
        ch_result = res_q;
    end

    always_comb begin
        vars_d  = vars_q;
        shamt_d = shamt_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        res_d   = res_q;
        x_d     = x_q;
        if (accept) begin
            vars_d  = vars;
            shamt_d = shamt;
            mode_d  = mode;
            idx_d   = '0;
            res_d   = '0;
        end else if (state_q == EVAL) begin
            res_d = res_upd;
            if (finish) x_d   = &res_upd;
            else        idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vars_q  <= '0;
            shamt_q <= '0;
            mode_q  <= '0;
            idx_q   <= '0;
            res_q   <= '0;
            x_q     <= 1'b0;
        end else begin
            vars_q  <= vars_d;
            shamt_q <= shamt_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
            x_q     <= x_d;
        end
    end

endmodule
